axil_xbar_1ton: RTL and testbench



---
 rtl/axil_xbar_1ton.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_axil_xbar_1ton.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_xbar_1ton.sv
// AXI4-Lite 1-to-N crossbar: decodes equal-size address windows and routes one write and one read at a time.
// Optional watchdog on stalled slaves: define XBAR_TIMEOUT_EN.
module axil_xbar_1ton #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int SLOT_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               axi_aclk,
  input  logic                               axi_areset,
  input  logic [ADDR_WIDTH-1:0]              s_axi_awaddr,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [DATA_WIDTH-1:0]              s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]            s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [DATA_WIDTH-1:0]              s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]              m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]              m_axi_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]              m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]              m_axi_wready,
  input  logic [NUM_SLAVES*2-1:0]            m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]              m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]              m_axi_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [NUM_SLAVES-1:0]              m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]              m_axi_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [NUM_SLAVES*2-1:0]            m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]              m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]              m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int RESP_W     = 2;
  localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1'b1);

  localparam logic [2:0] W_IDLE = 3'd0, W_ADDR = 3'd1, W_ISSUE = 3'd2, W_WAIT = 3'd3, W_RESP = 3'd4;
  localparam logic [2:0] R_IDLE = 3'd0, R_ADDR = 3'd1, R_ISSUE = 3'd2, R_WAIT = 3'd3, R_RESP = 3'd4;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axil_xbar_1ton: unsupported parameter set");
  end

  logic [2:0]            wr_state, rd_state;
  logic                  aw_seen, w_seen;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, wr_slot, rd_slot;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [SEL_W-1:0]      wr_sel, rd_sel, wr_dec, rd_dec;
  logic [NUM_SLAVES-1:0] wr_mask, rd_mask, wr_dec_mask, rd_dec_mask;
  logic [NUM_SLAVES-1:0] wr_bready, rd_rready;
  logic                  wr_hit, rd_hit, aw_take, w_take, wr_aw_done, wr_w_done;
  logic                  wr_expire, rd_expire, wr_blocked, rd_blocked;

  assign wr_slot     = wr_addr >> SLOT_BITS;
  assign rd_slot     = rd_addr >> SLOT_BITS;
  assign wr_hit      = (wr_slot < ADDR_WIDTH'(NUM_SLAVES));
  assign rd_hit      = (rd_slot < ADDR_WIDTH'(NUM_SLAVES));
  assign wr_dec      = wr_slot[SEL_W-1:0];
  assign rd_dec      = rd_slot[SEL_W-1:0];
  assign wr_dec_mask = ONE << wr_dec;
  assign rd_dec_mask = ONE << rd_dec;
  assign wr_mask     = ONE << wr_sel;
  assign rd_mask     = ONE << rd_sel;
  assign aw_take     = aw_seen || (s_axi_awready && s_axi_awvalid);
  assign w_take      = w_seen || (s_axi_wready && s_axi_wvalid);
  assign wr_aw_done  = !m_axi_awvalid[wr_sel] || m_axi_awready[wr_sel];
  assign wr_w_done   = !m_axi_wvalid[wr_sel] || m_axi_wready[wr_sel];

`ifdef XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      wr_cnt, rd_cnt;
  logic [NUM_SLAVES-1:0] wr_drain, rd_drain;

  // A slave that answers in the same cycle as the deadline still wins.
  assign wr_expire  = (wr_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                      ((wr_state == W_ISSUE) || ((wr_state == W_WAIT) && !m_axi_bvalid[wr_sel]));
  assign rd_expire  = (rd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                      ((rd_state == R_ISSUE) || ((rd_state == R_WAIT) && !m_axi_rvalid[rd_sel]));
  assign wr_blocked = |(wr_drain & wr_dec_mask);
  assign rd_blocked = |(rd_drain & rd_dec_mask);
  assign m_axi_bready = wr_bready | wr_drain;
  assign m_axi_rready = rd_rready | rd_drain;

  // Watchdog counters and the per-slave "swallow one late response" flags.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_drain <= '0;
      rd_drain <= '0;
    end else begin
      wr_cnt   <= (wr_state == W_ISSUE || wr_state == W_WAIT) ? wr_cnt + CNT_W'(1) : '0;
      rd_cnt   <= (rd_state == R_ISSUE || rd_state == R_WAIT) ? rd_cnt + CNT_W'(1) : '0;
      wr_drain <= (wr_drain & ~m_axi_bvalid) | ({NUM_SLAVES{wr_expire}} & wr_mask);
      rd_drain <= (rd_drain & ~m_axi_rvalid) | ({NUM_SLAVES{rd_expire}} & rd_mask);
    end
  end
`else
  assign wr_expire    = 1'b0;
  assign rd_expire    = 1'b0;
  assign wr_blocked   = 1'b0;
  assign rd_blocked   = 1'b0;
  assign m_axi_bready = wr_bready;
  assign m_axi_rready = rd_rready;
`endif

  // Write path: collect AW and W, forward to the decoded slave, return its response.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_state      <= W_IDLE;
      aw_seen       <= 1'b0;
      w_seen        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
      wr_sel        <= '0;
      wr_bready     <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (s_axi_awready && s_axi_awvalid) begin
            wr_addr       <= s_axi_awaddr;
            aw_seen       <= 1'b1;
            s_axi_awready <= 1'b0;
          end else begin
            s_axi_awready <= !aw_seen;
          end
          if (s_axi_wready && s_axi_wvalid) begin
            wr_data      <= s_axi_wdata;
            wr_strb      <= s_axi_wstrb;
            w_seen       <= 1'b1;
            s_axi_wready <= 1'b0;
          end else begin
            s_axi_wready <= !w_seen;
          end
          if (aw_take && w_take) wr_state <= W_ADDR;
        end
        W_ADDR: begin
          wr_sel <= wr_dec;
          if (!wr_hit) begin
            s_axi_bresp  <= 2'b11;
            s_axi_bvalid <= 1'b1;
            wr_state     <= W_RESP;
          end else if (!wr_blocked) begin
            m_axi_awaddr[wr_dec*ADDR_WIDTH +: ADDR_WIDTH] <= wr_addr;
            m_axi_wdata[wr_dec*DATA_WIDTH +: DATA_WIDTH]  <= wr_data;
            m_axi_wstrb[wr_dec*STRB_WIDTH +: STRB_WIDTH]  <= wr_strb;
            m_axi_awvalid <= wr_dec_mask;
            m_axi_wvalid  <= wr_dec_mask;
            wr_state      <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          if (wr_expire) begin
            m_axi_awvalid <= '0;
            m_axi_wvalid  <= '0;
            s_axi_bresp   <= 2'b10;
            s_axi_bvalid  <= 1'b1;
            wr_state      <= W_RESP;
          end else begin
            if (m_axi_awready[wr_sel]) m_axi_awvalid <= '0;
            if (m_axi_wready[wr_sel]) m_axi_wvalid <= '0;
            if (wr_aw_done && wr_w_done) begin
              wr_bready <= wr_mask;
              wr_state  <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (m_axi_bvalid[wr_sel]) begin
            s_axi_bresp  <= m_axi_bresp[wr_sel*RESP_W +: RESP_W];
            s_axi_bvalid <= 1'b1;
            wr_bready    <= '0;
            wr_state     <= W_RESP;
          end else if (wr_expire) begin
            s_axi_bresp  <= 2'b10;
            s_axi_bvalid <= 1'b1;
            wr_bready    <= '0;
            wr_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            aw_seen       <= 1'b0;
            w_seen        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read path: same shape as the write path with a single address channel.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rd_state      <= R_IDLE;
      rd_addr       <= '0;
      rd_sel        <= '0;
      rd_rready     <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_axi_arready && s_axi_arvalid) begin
            rd_addr       <= s_axi_araddr;
            s_axi_arready <= 1'b0;
            rd_state      <= R_ADDR;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_ADDR: begin
          rd_sel <= rd_dec;
          if (!rd_hit) begin
            s_axi_rresp  <= 2'b11;
            s_axi_rdata  <= '0;
            s_axi_rvalid <= 1'b1;
            rd_state     <= R_RESP;
          end else if (!rd_blocked) begin
            m_axi_araddr[rd_dec*ADDR_WIDTH +: ADDR_WIDTH] <= rd_addr;
            m_axi_arvalid <= rd_dec_mask;
            rd_state      <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          if (rd_expire) begin
            m_axi_arvalid <= '0;
            s_axi_rresp   <= 2'b10;
            s_axi_rdata   <= '0;
            s_axi_rvalid  <= 1'b1;
            rd_state      <= R_RESP;
          end else if (m_axi_arready[rd_sel]) begin
            m_axi_arvalid <= '0;
            rd_rready     <= rd_mask;
            rd_state      <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_axi_rvalid[rd_sel]) begin
            s_axi_rdata  <= m_axi_rdata[rd_sel*DATA_WIDTH +: DATA_WIDTH];
            s_axi_rresp  <= m_axi_rresp[rd_sel*RESP_W +: RESP_W];
            s_axi_rvalid <= 1'b1;
            rd_rready    <= '0;
            rd_state     <= R_RESP;
          end else if (rd_expire) begin
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b10;
            s_axi_rvalid <= 1'b1;
            rd_rready    <= '0;
            rd_state     <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_xbar_1ton.sv
// Scoreboard bench for axil_xbar_1ton: directed upstream transactions, behavioural slaves, queued expectations.
module tb_axil_xbar_1ton;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic s_axi_bready = 1'b1, s_axi_rready = 1'b1;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [DW-1:0] s_axi_rdata;
  logic [NS*AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [NS*DW-1:0] m_axi_wdata;
  logic [NS*DW/8-1:0] m_axi_wstrb;
  logic [NS-1:0] m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [NS-1:0] m_axi_awready = '0, m_axi_wready = '0, m_axi_bvalid = '0, m_axi_arready = '0, m_axi_rvalid = '0;
  logic [NS*2-1:0] m_axi_bresp = '0, m_axi_rresp = '0;
  logic [NS*DW-1:0] m_axi_rdata = '0;

  axil_xbar_1ton #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .SLOT_BITS(4), .TIMEOUT_CYCLES(64)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected traffic: {slave,addr}, {slave,strb,data}, bresp, {rresp,rdata}
  logic [11:0] exp_aw[$], exp_ar[$];
  logic [39:0] exp_w[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  // Slave model configuration and state
  int          aw_delay[NS];
  int          aw_cnt[NS];
  logic [1:0]  b_cfg[NS], rresp_cfg[NS];
  logic [31:0] rdata_cfg[NS];
  logic        silent[NS];
  logic        got_aw[NS], got_w[NS], got_ar[NS], b_fire[NS], r_fire[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slaves and monitor act on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (b_fire[i]) begin m_axi_bvalid[i] = 1'b0; b_fire[i] = 1'b0; end
      if (r_fire[i]) begin m_axi_rvalid[i] = 1'b0; r_fire[i] = 1'b0; end
      if (got_aw[i] && got_w[i]) begin
        m_axi_bvalid[i] = 1'b1;
        m_axi_bresp[i*2 +: 2] = b_cfg[i];
        got_aw[i] = 1'b0;
        got_w[i] = 1'b0;
      end
      if (got_ar[i]) begin
        m_axi_rvalid[i] = 1'b1;
        m_axi_rdata[i*DW +: DW] = rdata_cfg[i];
        m_axi_rresp[i*2 +: 2] = rresp_cfg[i];
        got_ar[i] = 1'b0;
      end
      m_axi_awready[i] = m_axi_awvalid[i] && (aw_cnt[i] >= aw_delay[i]);
      if (!m_axi_awvalid[i]) aw_cnt[i] = 0;
      else if (!m_axi_awready[i]) aw_cnt[i]++;
      m_axi_wready[i]  = m_axi_wvalid[i];
      m_axi_arready[i] = m_axi_arvalid[i];
      if (m_axi_awvalid[i] && m_axi_awready[i]) begin
        got_aw[i] = !silent[i];
        check("aw_pending", 64'(exp_aw.size() > 0), 64'd1);
        if (exp_aw.size() > 0) check("aw_fwd", {4'(i), m_axi_awaddr[i*AW +: AW]}, exp_aw.pop_front());
      end
      if (m_axi_wvalid[i] && m_axi_wready[i]) begin
        got_w[i] = !silent[i];
        check("w_pending", 64'(exp_w.size() > 0), 64'd1);
        if (exp_w.size() > 0) check("w_fwd", {4'(i), m_axi_wstrb[i*4 +: 4], m_axi_wdata[i*DW +: DW]}, exp_w.pop_front());
      end
      if (m_axi_arvalid[i] && m_axi_arready[i]) begin
        got_ar[i] = !silent[i];
        check("ar_pending", 64'(exp_ar.size() > 0), 64'd1);
        if (exp_ar.size() > 0) check("ar_fwd", {4'(i), m_axi_araddr[i*AW +: AW]}, exp_ar.pop_front());
      end
      if (m_axi_bvalid[i] && m_axi_bready[i]) b_fire[i] = 1'b1;
      if (m_axi_rvalid[i] && m_axi_rready[i]) r_fire[i] = 1'b1;
    end
    if (|m_axi_awvalid) check("aw_onehot", 64'($countones(m_axi_awvalid)), 64'd1);
    if (|m_axi_arvalid) check("ar_onehot", 64'($countones(m_axi_arvalid)), 64'd1);
    if (s_axi_bvalid && s_axi_bready) begin
      check("b_pending", 64'(exp_b.size() > 0), 64'd1);
      if (exp_b.size() > 0) check("bresp", s_axi_bresp, exp_b.pop_front());
    end
    if (s_axi_rvalid && s_axi_rready) begin
      check("r_pending", 64'(exp_r.size() > 0), 64'd1);
      if (exp_r.size() > 0) check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, exp_r.pop_front());
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_hs, w_hs;
    int n = 0;
    @(posedge clk); #1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    if (lead == 0) begin s_axi_awaddr = a; s_axi_awvalid = 1'b1; end
    while (!(aw_done && w_done) && n < 100) begin
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      n++;
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin s_axi_wvalid = 1'b0; w_done = 1'b1; end
      if (n == lead) begin s_axi_awaddr = a; s_axi_awvalid = 1'b1; end
    end
    check("wr_accept", 64'(aw_done && w_done), 64'd1);
  endtask

  task automatic rd(input logic [7:0] a);
    bit done = 1'b0;
    bit hs;
    int n = 0;
    @(posedge clk); #1;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1;
      n++;
      if (hs) begin s_axi_arvalid = 1'b0; done = 1'b1; end
    end
    check("rd_accept", 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((exp_b.size() + exp_r.size()) > 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("resp_drained", 64'(exp_b.size() + exp_r.size()), 64'd0);
  endtask

  initial begin
    int k;
    logic [1:0] held;
    for (int i = 0; i < NS; i++) begin
      aw_delay[i] = 0; aw_cnt[i] = 0; b_cfg[i] = 2'b00; rresp_cfg[i] = 2'b00;
      rdata_cfg[i] = 32'h1000_0000 + 32'(i); silent[i] = 1'b0;
      got_aw[i] = 1'b0; got_w[i] = 1'b0; got_ar[i] = 1'b0; b_fire[i] = 1'b0; r_fire[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ctl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid, s_axi_rresp}, 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_m_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
    check("rst_m_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
    check("rst_m_wdata", 64'(|{m_axi_wdata, m_axi_wstrb}), 64'd0);
    rst = 1'b0;

    // Write slave 1, AW and W together, zero-wait slave
    exp_aw.push_back({4'd1, 8'h14}); exp_w.push_back({4'd1, 4'hF, 32'hDEADBEEF}); exp_b.push_back(2'b00);
    wr(8'h14, 32'hDEADBEEF, 4'hF, 0);
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin k = j; break; end
    end
    check("b_latency", 64'(k), 64'd4);
    wait_idle(50);

    // W three cycles ahead of AW, slow awready on slave 2, SLVERR passthrough
    aw_delay[2] = 5; b_cfg[2] = 2'b10;
    exp_aw.push_back({4'd2, 8'h24}); exp_w.push_back({4'd2, 4'h3, 32'h0000A5A5}); exp_b.push_back(2'b10);
    wr(8'h24, 32'h0000A5A5, 4'h3, 3);
    wait_idle(50);
    aw_delay[2] = 0; b_cfg[2] = 2'b00;

    // Read hit on slave 1 with latency check, then unmapped read
    rdata_cfg[1] = 32'h1111_2222;
    exp_ar.push_back({4'd1, 8'h18}); exp_r.push_back({2'b00, 32'h1111_2222});
    rd(8'h18);
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin k = j; break; end
    end
    check("r_latency", 64'(k), 64'd4);
    wait_idle(50);
    exp_r.push_back({2'b11, 32'h0});
    rd(8'h40);
    wait_idle(50);

    // Unmapped write
    exp_b.push_back(2'b11);
    wr(8'h50, 32'h12345678, 4'hF, 0);
    wait_idle(50);

    // Concurrent write to slave 0 and read from slave 3
    rdata_cfg[3] = 32'hCAFEF00D; rresp_cfg[3] = 2'b10;
    exp_aw.push_back({4'd0, 8'h08}); exp_w.push_back({4'd0, 4'hC, 32'h0BADC0DE}); exp_b.push_back(2'b00);
    exp_ar.push_back({4'd3, 8'h3C}); exp_r.push_back({2'b10, 32'hCAFEF00D});
    fork
      wr(8'h08, 32'h0BADC0DE, 4'hC, 0);
      rd(8'h3C);
    join
    wait_idle(50);

    // Upstream bready held low: response must hold steady, no new AW accepted
    b_cfg[1] = 2'b01;
    s_axi_bready = 1'b0;
    exp_aw.push_back({4'd1, 8'h10}); exp_w.push_back({4'd1, 4'hF, 32'h55AA55AA}); exp_b.push_back(2'b01);
    wr(8'h10, 32'h55AA55AA, 4'hF, 0);
    k = 0;
    while (!s_axi_bvalid && k < 10) begin @(negedge clk); k++; end
    held = s_axi_bresp;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("hold_bvalid", {s_axi_bvalid, s_axi_awready, s_axi_bresp, held}, {1'b1, 1'b0, 2'b01, 2'b01});
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    wait_idle(50);
    b_cfg[1] = 2'b00;

    // Reset while the write waits on a silent slave 3
    silent[3] = 1'b1;
    exp_aw.push_back({4'd3, 8'h30}); exp_w.push_back({4'd3, 4'hF, 32'h0F0F0F0F});
    wr(8'h30, 32'h0F0F0F0F, 4'hF, 0);
    repeat (4) @(negedge clk);
    check("wait_bready", m_axi_bready, 64'h8);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_s_ctl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid, s_axi_rresp}, 64'd0);
    check("arst_m_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
    check("arst_m_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_aw.push_back({4'd2, 8'h2C}); exp_w.push_back({4'd2, 4'h1, 32'h000000AB}); exp_b.push_back(2'b00);
    wr(8'h2C, 32'h000000AB, 4'h1, 0);
    wait_idle(50);

`ifdef XBAR_TIMEOUT_EN
    // Silent slave answered by the watchdog with SLVERR
    exp_aw.push_back({4'd3, 8'h34}); exp_w.push_back({4'd3, 4'hF, 32'h77777777}); exp_b.push_back(2'b10);
    wr(8'h34, 32'h77777777, 4'hF, 0);
    wait_idle(200);
`endif

    repeat (3) @(negedge clk);
    check("fwd_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
